// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Parametrised synchronous up/down counter with programmable modulus
//   (0..MAX_VAL), count enable, parallel load with clamping, direction
//   select, combinational terminal-count flag and a registered wrap pulse.
//   Priority on each rising clk edge: reset > load > en > hold.
//
//   Optional feature macro: COUNTER_SAT_EN
//     Defined   -> adds input sat and sticky output ovf. With sat=1 the count
//                  holds at the boundary instead of wrapping, and ovf is set.
//     Undefined -> no sat/ovf ports; the counter always wraps.
module param_updown_counter #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
`ifdef COUNTER_SAT_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] carry;       // ripple chain: toggle bit i when carry[i]=1
    logic [WIDTH-1:0] stepped;     // count +/- 1 in plain binary
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
`ifdef COUNTER_SAT_EN
    logic             ovf_next;
`endif

    // Terminal count: the boundary the counter is heading towards right now.
    assign tc = up_dn ? (count == MAX_VAL) : (count == '0);

    // Ripple-carry incrementer/decrementer: a bit flips when every lower bit
    // equals the direction bit (all ones going up, all zeros going down).
    // The carry out of the top bit is never formed; the modulus is applied
    // by the boundary check below, not by the adder.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = carry[i-1] & (count[i-1] ~^ up_dn);
        end
        stepped = count ^ carry;
    end

    // Next-state selection in priority order load > en > hold (reset is
    // applied in the register process).
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned -- otherwise synthesis infers a latch.
        count_next = count;
        wrap_next  = 1'b0;
`ifdef COUNTER_SAT_EN
        ovf_next   = ovf;
`endif
        if (load) begin
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
`ifdef COUNTER_SAT_EN
            ovf_next   = 1'b0;
`endif
        end else if (en) begin
            if (!tc) begin
                count_next = stepped;
`ifdef COUNTER_SAT_EN
            end else if (sat) begin
                // Saturate: stay on the boundary and remember the attempt.
                count_next = count;
                ovf_next   = 1'b1;
`endif
            end else begin
                count_next = up_dn ? '0 : MAX_VAL;
                wrap_next  = 1'b1;
            end
        end
    end

    // Count register, wrap flop and (optionally) sticky overflow flop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            count <= RESET_VAL;
            wrap  <= 1'b0;
`ifdef COUNTER_SAT_EN
            ovf   <= 1'b0;
`endif
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
`ifdef COUNTER_SAT_EN
            ovf   <= ovf_next;
`endif
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter
//   Directed, table-driven bench for param_updown_counter with WIDTH=4,
//   MAX_VAL=9, RESET_VAL=0. Optional COUNTER_SAT_EN checks are compiled in
//   when that macro is defined for both bench and design.
module tb_param_updown_counter;

    localparam int              WIDTH     = 4;
    localparam logic [WIDTH-1:0] MAX_VAL   = 4'd9;
    localparam logic [WIDTH-1:0] RESET_VAL = 4'd0;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
`ifdef COUNTER_SAT_EN
    logic             sat;
    logic             ovf;
`endif

    int checks_total;
    int checks_passed;

    typedef struct {
        logic             reset;
        logic             en;
        logic             up_dn;
        logic             load;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] exp_count;
        logic             exp_wrap;
        logic             exp_tc;
    } vec_t;

    vec_t vecs[$];

    param_updown_counter #(
        .WIDTH     (WIDTH),
        .MAX_VAL   (MAX_VAL),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
`ifdef COUNTER_SAT_EN
        .sat      (sat),
`endif
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
`ifdef COUNTER_SAT_EN
        ,
        .ovf      (ovf)
`endif
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        else
            checks_passed++;
    endtask

    task automatic add(input logic r, input logic e, input logic u, input logic l,
                       input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] c,
                       input logic w, input logic t);
        vec_t v;
        v.reset = r; v.en = e; v.up_dn = u; v.load = l; v.load_val = lv;
        v.exp_count = c; v.exp_wrap = w; v.exp_tc = t;
        vecs.push_back(v);
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [WIDTH-1:0] lv);
        @(negedge clk);
        reset = r; en = e; up_dn = u; load = l; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
`ifdef COUNTER_SAT_EN
        sat = 1'b0;
`endif

        //   reset en up load val   count wrap tc
        // Reset with en=1 up=1, then 10 enabled up edges: 1..9,0.
        add(1, 1, 1, 0, 4'd0,  4'd0, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd1, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd2, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd3, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd4, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd5, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd6, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd7, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd8, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd9, 0, 1);
        add(0, 1, 1, 0, 4'd0,  4'd0, 1, 0);
        // Down wrap: load 2, then 1,0,9,8.
        add(0, 0, 1, 1, 4'd2,  4'd2, 0, 0);
        add(0, 1, 0, 0, 4'd0,  4'd1, 0, 0);
        add(0, 1, 0, 0, 4'd0,  4'd0, 0, 1);
        add(0, 1, 0, 0, 4'd0,  4'd9, 1, 0);
        add(0, 1, 0, 0, 4'd0,  4'd8, 0, 0);
        // Load beats en and clamps F to 9; then load 5.
        add(0, 1, 1, 1, 4'hF,  4'd9, 0, 1);
        add(0, 1, 1, 1, 4'd5,  4'd5, 0, 0);
        // Hold for three edges, then toggle direction every edge.
        add(0, 0, 1, 0, 4'd0,  4'd5, 0, 0);
        add(0, 0, 1, 0, 4'd0,  4'd5, 0, 0);
        add(0, 0, 1, 0, 4'd0,  4'd5, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd6, 0, 0);
        add(0, 1, 0, 0, 4'd0,  4'd5, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd6, 0, 0);
        add(0, 1, 0, 0, 4'd0,  4'd5, 0, 0);
        // Reset beats load mid-operation, counting resumes from 0.
        add(0, 0, 1, 1, 4'd7,  4'd7, 0, 0);
        add(1, 1, 1, 1, 4'd3,  4'd0, 0, 0);
        add(0, 1, 1, 0, 4'd0,  4'd1, 0, 0);
        // Reset while counting down: tc reflects count=0 in the down direction.
        add(1, 1, 0, 0, 4'd0,  4'd0, 0, 1);
        // Load of exactly MAX_VAL is not clamped differently; load 0 with up.
        add(0, 0, 0, 1, 4'd9,  4'd9, 0, 0);
        add(0, 0, 1, 1, 4'd0,  4'd0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].reset, vecs[i].en, vecs[i].up_dn, vecs[i].load, vecs[i].load_val);
            check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("v%0d wrap", i),  32'(wrap),  32'(vecs[i].exp_wrap));
            check($sformatf("v%0d tc", i),    32'(tc),    32'(vecs[i].exp_tc));
        end

        // tc is combinational on up_dn: at count=0 flip direction without an edge.
        @(negedge clk);
        en = 1'b0; load = 1'b0; up_dn = 1'b1;
        #1 check("tc_comb_up", 32'(tc), 32'd0);
        up_dn = 1'b0;
        #1 check("tc_comb_dn", 32'(tc), 32'd1);

        // Wrap pulse lasts exactly one cycle even with en held: load 7, count
        // up with a bounded wait for wrap, then confirm it drops next edge.
        step(0, 0, 1, 1, 4'd7);
        begin
            int cycles;
            cycles = 0;
            @(negedge clk);
            load = 1'b0; en = 1'b1; up_dn = 1'b1;
            while (wrap !== 1'b1 && cycles < 20) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            check("wrap_seen", 32'(wrap), 32'd1);
            check("wrap_latency", 32'(cycles), 32'd3);
            check("wrap_count0", 32'(count), 32'd0);
            @(posedge clk);
            #1;
            check("wrap_one_cycle", 32'(wrap), 32'd0);
            check("after_wrap_count", 32'(count), 32'd1);
        end

`ifdef COUNTER_SAT_EN
        // Saturation: from 8 counting up with sat=1 -> 9,9,9; ovf after the
        // second edge; wrap never; load clears ovf.
        @(negedge clk);
        sat = 1'b1;
        step(0, 0, 1, 1, 4'd8);
        check("sat_load8", 32'(count), 32'd8);
        check("sat_ovf0", 32'(ovf), 32'd0);
        step(0, 1, 1, 0, 4'd0);
        check("sat_e1_count", 32'(count), 32'd9);
        check("sat_e1_ovf", 32'(ovf), 32'd0);
        step(0, 1, 1, 0, 4'd0);
        check("sat_e2_count", 32'(count), 32'd9);
        check("sat_e2_ovf", 32'(ovf), 32'd1);
        check("sat_e2_wrap", 32'(wrap), 32'd0);
        step(0, 1, 1, 0, 4'd0);
        check("sat_e3_count", 32'(count), 32'd9);
        check("sat_e3_ovf", 32'(ovf), 32'd1);
        check("sat_e3_wrap", 32'(wrap), 32'd0);
        step(0, 0, 1, 1, 4'd0);
        check("sat_load_clr", 32'(ovf), 32'd0);
        // Down saturation at 0, then sat=0 wraps without setting ovf.
        step(0, 1, 0, 0, 4'd0);
        check("sat_dn_count", 32'(count), 32'd0);
        check("sat_dn_ovf", 32'(ovf), 32'd1);
        step(1, 0, 0, 0, 4'd0);
        check("sat_rst_clr", 32'(ovf), 32'd0);
        @(negedge clk);
        sat = 1'b0;
        step(0, 1, 0, 0, 4'd0);
        check("nosat_count", 32'(count), 32'd9);
        check("nosat_wrap", 32'(wrap), 32'd1);
        check("nosat_ovf", 32'(ovf), 32'd0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
